// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory fetch port: fault codes, the
// buffered response record and the built-in boot image.
package imem_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } imem_fault_e;

    typedef struct packed {
        logic [31:0] inst;
        imem_fault_e fault;
    } imem_rsp_t;

    localparam int RSP_W = $bits(imem_rsp_t);

    // Boot program placed at the bottom of memory; everything above it is zero.
    function automatic logic [31:0] boot_word(input int idx);
        case (idx)
            32'sd0:  return 32'h0F05_3483;
            32'sd1:  return 32'h009A_84B3;
            32'sd2:  return 32'h0014_8493;
            32'sd3:  return 32'h0E95_3823;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry response FIFO. Entry 0 is always the head so the consumer sees
// register outputs directly; the buffer is flushed asynchronously by rst_n.
module imem_rsp_fifo
    import imem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [RSP_W-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [RSP_W-1:0] head_data
);

    logic [RSP_W-1:0] slot0_r;
    logic [RSP_W-1:0] slot1_r;
    logic [1:0]       count_r;
    logic [1:0]       cnt_nxt_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop against the occupancy and derive the next count.
    always_comb begin
        push_ok_s = push && (count_r != 2'd2);
        pop_ok_s  = pop && (count_r != 2'd0);
        if (push_ok_s && !pop_ok_s) begin
            cnt_nxt_s = count_r + 2'd1;
        end else if (pop_ok_s && !push_ok_s) begin
            cnt_nxt_s = count_r - 2'd1;
        end else begin
            cnt_nxt_s = count_r;
        end
    end

    // Storage and occupancy; a pop with two entries shifts the tail into the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_r <= '0;
            slot1_r <= '0;
            count_r <= 2'd0;
        end else begin
            count_r <= cnt_nxt_s;
            case (count_r)
                2'd0: begin
                    if (push_ok_s) begin
                        slot0_r <= push_data;
                    end
                end
                2'd1: begin
                    if (push_ok_s && pop_ok_s) begin
                        slot0_r <= push_data;
                    end else if (push_ok_s) begin
                        slot1_r <= push_data;
                    end
                end
                2'd2: begin
                    if (pop_ok_s) begin
                        slot0_r <= slot1_r;
                    end
                end
                default: begin
                    slot0_r <= slot0_r;
                end
            endcase
        end
    end

    assign count     = count_r;
    assign head_data = slot0_r;

endmodule

// File: rtl/imem_fetch_port.sv
// Byte-addressed instruction memory with a valid/ready fetch channel and a
// 2-deep response buffer. Optional byte write port: IMEM_WRITE_PORT_EN.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int    ADDR_W      = 64,
    parameter int    DEPTH_WORDS = 16,
    parameter string INIT_FILE   = "imem_init.hex"
) (
    input  logic              clk,
    input  logic              reset,
`ifdef IMEM_WRITE_PORT_EN
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_inst,
    output logic [1:0]        rsp_fault
);

    localparam int                BYTES      = DEPTH_WORDS * 4;
    localparam int                IDX_W      = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] BYTE_LIMIT = ADDR_W'(BYTES);

    // The default image name maps to the boot program; an empty name starts cleared.
    function automatic logic [BYTES-1:0][7:0] build_image();
        logic [BYTES-1:0][7:0] img;
        logic [31:0]           word;
        img = '0;
        if (INIT_FILE != "") begin
            for (int w = 0; w < 4; w++) begin
                word = boot_word(w);
                img[IDX_W'(w * 4 + 0)] = word[7:0];
                img[IDX_W'(w * 4 + 1)] = word[15:8];
                img[IDX_W'(w * 4 + 2)] = word[23:16];
                img[IDX_W'(w * 4 + 3)] = word[31:24];
            end
        end else begin
            img = '0;
        end
        return img;
    endfunction

    localparam logic [BYTES-1:0][7:0] BOOT_IMAGE = build_image();

`ifdef IMEM_WRITE_PORT_EN
    logic [BYTES-1:0][7:0] mem_r = BOOT_IMAGE;
    logic                  wr_hit_s;

    assign wr_hit_s = wr_en && (wr_addr < BYTE_LIMIT);

    // Byte writes; the fetch decode below samples the pre-edge contents.
    always_ff @(posedge clk) begin
        if (wr_hit_s) begin
            mem_r[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end
`else
    logic [BYTES-1:0][7:0] mem_r;

    assign mem_r = BOOT_IMAGE;
`endif

    imem_rsp_t        rd_rsp_s;
    imem_rsp_t        head_s;
    logic [IDX_W-3:0] word_base_s;
    logic [1:0]       count_s;
    logic [RSP_W-1:0] head_data_s;
    logic             accept_s;
    logic             pop_s;

    // Fault classification; misalignment wins and faulted fetches never touch memory.
    always_comb begin
        rd_rsp_s.inst  = NOP_INST;
        rd_rsp_s.fault = FAULT_NONE;
        word_base_s    = req_addr[IDX_W-1:2];
        if (req_addr[1:0] != 2'b00) begin
            rd_rsp_s.fault = FAULT_MISALIGN;
        end else if (req_addr >= BYTE_LIMIT) begin
            rd_rsp_s.fault = FAULT_RANGE;
        end else begin
            rd_rsp_s.inst = {mem_r[{word_base_s, 2'b11}], mem_r[{word_base_s, 2'b10}],
                             mem_r[{word_base_s, 2'b01}], mem_r[{word_base_s, 2'b00}]};
        end
    end

    assign accept_s = req_valid && req_ready;
    assign pop_s    = rsp_valid && rsp_ready;

    imem_rsp_fifo u_rsp_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (accept_s),
        .push_data (rd_rsp_s),
        .pop       (pop_s),
        .count     (count_s),
        .head_data (head_data_s)
    );

    assign head_s    = imem_rsp_t'(head_data_s);
    assign req_ready = (count_s != 2'd2);
    assign rsp_valid = (count_s != 2'd0);
    assign rsp_inst  = head_s.inst;
    assign rsp_fault = head_s.fault;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Self-checking bench for imem_fetch_port: vector table plus hand sequences,
// with a queue scoreboard and an occupancy model checked every cycle.
`timescale 1ns/1ps
module tb_imem_fetch_port;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [63:0] req_addr  = 64'h0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_inst;
    logic [1:0]  rsp_fault;
`ifdef IMEM_WRITE_PORT_EN
    logic        wr_en   = 1'b0;
    logic [63:0] wr_addr = 64'h0;
    logic [7:0]  wr_data = 8'h00;
`endif

    imem_fetch_port dut (
        .clk       (clk),
        .reset     (reset),
`ifdef IMEM_WRITE_PORT_EN
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_fault (rsp_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [1:0]  fault;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
        logic [1:0]  fault;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[10];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          model_cnt = 0;
    logic        last_accept = 1'b0;
    logic [31:0] pend_inst = 32'h0;
    logic [1:0]  pend_fault = 2'b00;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, applied 1ns after the rising edge.
    task automatic drive(input logic v, input logic [63:0] a, input logic [31:0] ei,
                         input logic [1:0] ef, input logic rr);
        req_valid  = v;
        req_addr   = a;
        pend_inst  = ei;
        pend_fault = ef;
        rsp_ready  = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 64'h0, 32'h0, 2'b00, 1'b1);
    endtask

    // Monitor on the falling edge: occupancy model, scoreboard push/pop.
    initial begin
        exp_t e;
        logic do_pop;
        logic do_push;
        forever begin
            @(negedge clk);
            if (!reset) begin
                model_cnt   = 0;
                sb_q.delete();
                last_accept = 1'b0;
            end else begin
                chk("rsp_valid", {63'h0, rsp_valid}, {63'h0, model_cnt != 0});
                chk("req_ready", {63'h0, req_ready}, {63'h0, model_cnt != 2});
                do_pop  = (model_cnt != 0) && rsp_ready;
                do_push = req_valid && (model_cnt != 2);
                if (do_pop) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_underflow: got a pop with no expected entry at %0t", $time);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rsp_inst", {32'h0, rsp_inst}, {32'h0, e.inst});
                        chk("rsp_fault", {62'h0, rsp_fault}, {62'h0, e.fault});
                    end
                end
                if (do_push) sb_q.push_back({pend_inst, pend_fault});
                model_cnt   = model_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
                last_accept = do_push;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{64'h0,                   32'h0F05_3483, 2'b00};
        vecs[1] = '{64'h4,                   32'h009A_84B3, 2'b00};
        vecs[2] = '{64'h8,                   32'h0014_8493, 2'b00};
        vecs[3] = '{64'hC,                   32'h0E95_3823, 2'b00};
        vecs[4] = '{64'h6,                   NOP,           2'b01};
        vecs[5] = '{64'h40,                  NOP,           2'b10};
        vecs[6] = '{64'h42,                  NOP,           2'b01};
        vecs[7] = '{64'h3C,                  32'h0000_0000, 2'b00};
        vecs[8] = '{64'h3D,                  NOP,           2'b01};
        vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFC, NOP,           2'b10};

        // Reset values before any clock edge.
        #3;
        chk("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("reset_req_ready", {63'h0, req_ready}, 64'h1);
        chk("reset_rsp_inst",  {32'h0, rsp_inst},  64'h0);
        chk("reset_rsp_fault", {62'h0, rsp_fault}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);

        // Back-to-back table fetches at full throughput.
        for (int i = 0; i < 10; i++) drive(1'b1, vecs[i].addr, vecs[i].inst, vecs[i].fault, 1'b1);
        idle(3);

        // Back-pressure: two accepted, third held until space frees.
        drive(1'b1, 64'h0, 32'h0F05_3483, 2'b00, 1'b0);
        drive(1'b1, 64'h4, 32'h009A_84B3, 2'b00, 1'b0);
        drive(1'b1, 64'h8, 32'h0014_8493, 2'b00, 1'b0);
        chk("bp_third_blocked", {63'h0, last_accept}, 64'h0);
        drive(1'b1, 64'h8, 32'h0014_8493, 2'b00, 1'b0);
        chk("bp_hold_stable", {32'h0, rsp_inst}, 64'h0F05_3483);
        begin
            logic got = 1'b0;
            for (int i = 0; i < 8 && !got; i++) begin
                drive(1'b1, 64'h8, 32'h0014_8493, 2'b00, 1'b1);
                got = last_accept;
            end
            chk("bp_third_accepted", {63'h0, got}, 64'h1);
        end
        idle(4);

`ifdef IMEM_WRITE_PORT_EN
        // Same-edge read returns old data; later fetch sees the new bytes.
        wr_en = 1'b1; wr_addr = 64'h4; wr_data = 8'hB3;
        drive(1'b1, 64'h4, 32'h009A_84B3, 2'b00, 1'b1);
        wr_addr = 64'h5; wr_data = 8'h04;
        drive(1'b0, 64'h0, 32'h0, 2'b00, 1'b1);
        wr_addr = 64'h6; wr_data = 8'h00;
        drive(1'b0, 64'h0, 32'h0, 2'b00, 1'b1);
        wr_addr = 64'h7; wr_data = 8'h00;
        drive(1'b0, 64'h0, 32'h0, 2'b00, 1'b1);
        wr_addr = 64'h40; wr_data = 8'hFF;
        drive(1'b1, 64'h4, 32'h0000_04B3, 2'b00, 1'b1);
        wr_en = 1'b0;
        idle(3);
`endif

        // Asynchronous flush with two entries buffered.
        drive(1'b1, 64'h0, 32'h0F05_3483, 2'b00, 1'b0);
        drive(1'b1, 64'h4, 32'h009A_84B3, 2'b00, 1'b0);
        chk("pre_flush_valid", {63'h0, rsp_valid}, 64'h1);
        req_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("flush_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("flush_req_ready", {63'h0, req_ready}, 64'h1);
        chk("flush_rsp_inst",  {32'h0, rsp_inst},  64'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);
        drive(1'b1, 64'h8, 32'h0014_8493, 2'b00, 1'b1);
        idle(3);

        chk("sb_drained", {32'h0, sb_q.size()}, 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
